// File: rtl/rlbp_pixel_sequencer_pkg.sv
// Shared types and defaults for the rlbp readout sequencer.
package rlbp_seq_pkg;

    localparam int NUM_PD_DEF      = 12;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int IDX_W           = $clog2(NUM_PD_DEF);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        INTEG,
        SH,
        SEL,
        CMP,
        LATCH,
        DONE
    } state_t;

endpackage

// File: rtl/rlbp_pixel_sequencer_timer.sv
// Loadable down-counter shared by every phase; a programmed length of 0 behaves as 1.
module rlbp_phase_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] len,
    output logic          done
);

    logic [TW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (len == '0) ? '0 : len - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/rlbp_pixel_sequencer.sv
// Frame sequencer: drives the analog phases, walks the photodiode pairs and packs the comparator decisions.
module rlbp_pixel_sequencer
    import rlbp_seq_pkg::*;
#(
    parameter int NUM_PD      = NUM_PD_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TW          = 16,
    parameter int PW          = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic              cont_i,
    input  logic              abort_i,
    input  logic [PW-1:0]     t_rst_i,
    input  logic [TW-1:0]     t_int_i,
    input  logic [PW-1:0]     t_sh_i,
    input  logic [PW-1:0]     t_sel_i,
    input  logic [PW-1:0]     t_cmp_i,
    input  logic              cmp_i,
    output logic              sh_rst_o,
    output logic              sw1_o,
    output logic              sw2_o,
    output logic              sh_o,
    output logic              sh_cmp_o,
    output logic [NUM_PD-1:0] pd_a_o,
    output logic [NUM_PD-1:0] pd_b_o,
    output logic [NUM_PD-1:0] code_o,
    output logic              code_valid_o,
    input  logic              code_ready_i,
    output logic              busy_o,
    output logic              frame_done_o
);

    typedef struct packed {
        logic              sh_rst;
        logic              sw1;
        logic              sw2;
        logic              sh;
        logic              sh_cmp;
        logic              busy;
        logic [NUM_PD-1:0] pd;
    } ctrl_t;

    // Control word for the state being entered; registering it keeps the analog phases glitch-free.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [IDX_W-1:0] sel_idx);
        ctrl_t c;
        c      = '0;
        c.busy = (st != IDLE);
        case (st)
            RST:        c.sh_rst = 1'b1;
            INTEG:      c.sw1    = 1'b1;
            SH:         begin c.sh = 1'b1; c.sw2 = 1'b1; end
            SEL, LATCH: c.pd     = NUM_PD'(1) << sel_idx;
            CMP:        begin c.pd = NUM_PD'(1) << sel_idx; c.sh_cmp = 1'b1; end
            default:    ;
        endcase
        return c;
    endfunction

    state_t                 state;
    ctrl_t                  ctrl;
    logic [IDX_W-1:0]       idx;
    logic [NUM_PD-1:0]      shreg;
    logic [SYNC_STAGES-1:0] sync;
    logic                   cmp_s;
    logic                   tmr_load;
    logic [TW-1:0]          tmr_len;
    logic                   tmr_done;
    logic                   can_load;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) sync <= '0;
        else            sync <= {sync[SYNC_STAGES-2:0], cmp_i};
    end
    assign cmp_s = sync[SYNC_STAGES-1];

    // The timer is reloaded with the next phase's length on the edge that leaves the current phase.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        tmr_load = tmr_done;
        tmr_len  = '0;
        case (state)
            IDLE:    begin tmr_load = 1'b1; tmr_len = TW'(t_rst_i); end
            RST:     tmr_len = t_int_i;
            INTEG:   tmr_len = TW'(t_sh_i);
            SH:      tmr_len = TW'(t_sel_i);
            SEL:     tmr_len = TW'(t_cmp_i);
            CMP:     tmr_len = TW'(SYNC_STAGES + 1);
            LATCH:   tmr_len = TW'(t_sel_i);
            DONE:    begin tmr_load = 1'b1; tmr_len = TW'(t_rst_i); end
            default: ;
        endcase
    end

    rlbp_phase_timer #(.TW(TW)) u_timer (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .load  (tmr_load),
        .len   (tmr_len),
        .done  (tmr_done)
    );

    assign can_load = !code_valid_o || code_ready_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= IDLE;
            ctrl         <= '0;
            idx          <= '0;
            shreg        <= '0;
            code_o       <= '0;
            code_valid_o <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (code_valid_o && code_ready_i) code_valid_o <= 1'b0;

            if (abort_i) begin
                state <= IDLE;
                ctrl  <= '0;
                idx   <= '0;
                shreg <= '0;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        state <= RST;
                        idx   <= '0;
                        shreg <= '0;
                        ctrl  <= ctrl_for(RST, '0);
                    end
                    RST: if (tmr_done) begin
                        state <= INTEG;
                        ctrl  <= ctrl_for(INTEG, idx);
                    end
                    INTEG: if (tmr_done) begin
                        state <= SH;
                        ctrl  <= ctrl_for(SH, idx);
                    end
                    SH: if (tmr_done) begin
                        state <= SEL;
                        ctrl  <= ctrl_for(SEL, idx);
                    end
                    SEL: if (tmr_done) begin
                        state <= CMP;
                        ctrl  <= ctrl_for(CMP, idx);
                    end
                    CMP: if (tmr_done) begin
                        state <= LATCH;
                        ctrl  <= ctrl_for(LATCH, idx);
                    end
                    LATCH: if (tmr_done) begin
                        shreg[idx] <= cmp_s;
                        if (idx == IDX_W'(NUM_PD - 1)) begin
                            state <= DONE;
                            ctrl  <= ctrl_for(DONE, idx);
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SEL;
                            ctrl  <= ctrl_for(SEL, idx + 1'b1);
                        end
                    end
                    DONE: if (can_load) begin
                        code_o       <= shreg;
                        code_valid_o <= 1'b1;
                        frame_done_o <= 1'b1;
                        idx          <= '0;
                        if (cont_i) begin
                            state <= RST;
                            shreg <= '0;
                            ctrl  <= ctrl_for(RST, '0);
                        end else begin
                            state <= IDLE;
                            ctrl  <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        ctrl  <= '0;
                    end
                endcase
            end
        end
    end

    assign sh_rst_o = ctrl.sh_rst;
    assign sw1_o    = ctrl.sw1;
    assign sw2_o    = ctrl.sw2;
    assign sh_o     = ctrl.sh;
    assign sh_cmp_o = ctrl.sh_cmp;
    assign busy_o   = ctrl.busy;
    assign pd_a_o   = ctrl.pd;
    assign pd_b_o   = ctrl.pd;

endmodule

// File: tb/tb_rlbp_pixel_sequencer.sv
// Self-checking bench: per-cycle phase model derived from the frame timing rules, plus handshake corner cases.
module tb_rlbp_pixel_sequencer;

    localparam int NPD  = 12;
    localparam int SYNC = 2;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_ni;
    logic            start_i, cont_i, abort_i, code_ready_i;
    logic [7:0]      t_rst_i, t_sh_i, t_sel_i, t_cmp_i;
    logic [15:0]     t_int_i;
    logic            cmp_i;
    logic            sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o;
    logic [NPD-1:0]  pd_a_o, pd_b_o, code_o;
    logic            code_valid_o, busy_o, frame_done_o;
    logic [NPD-1:0]  pattern = '0;

    int n_checks = 0;
    int n_errors = 0;

    rlbp_pixel_sequencer dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_ni    (wb_rst_ni),
        .start_i      (start_i),
        .cont_i       (cont_i),
        .abort_i      (abort_i),
        .t_rst_i      (t_rst_i),
        .t_int_i      (t_int_i),
        .t_sh_i       (t_sh_i),
        .t_sel_i      (t_sel_i),
        .t_cmp_i      (t_cmp_i),
        .cmp_i        (cmp_i),
        .sh_rst_o     (sh_rst_o),
        .sw1_o        (sw1_o),
        .sw2_o        (sw2_o),
        .sh_o         (sh_o),
        .sh_cmp_o     (sh_cmp_o),
        .pd_a_o       (pd_a_o),
        .pd_b_o       (pd_b_o),
        .code_o       (code_o),
        .code_valid_o (code_valid_o),
        .code_ready_i (code_ready_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Analog stand-in: the comparator reports the bit of the currently selected pair.
    assign cmp_i = |(pd_a_o & pattern);

    typedef struct packed {
        logic           busy, sh_rst, sw1, sw2, sh, sh_cmp;
        logic [NPD-1:0] pd_a, pd_b;
        logic           valid, done;
    } obs_t;

    typedef struct {
        int             tr, ti, ts, tsl, tc;
        logic [NPD-1:0] pat;
        int             vcyc;
    } vec_t;

    typedef enum int { EV_NONE, EV_ABORT, EV_RESET, EV_RESTART } ev_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy   = busy_o;
        o.sh_rst = sh_rst_o;
        o.sw1    = sw1_o;
        o.sw2    = sw2_o;
        o.sh     = sh_o;
        o.sh_cmp = sh_cmp_o;
        o.pd_a   = pd_a_o;
        o.pd_b   = pd_b_o;
        o.valid  = code_valid_o;
        o.done   = frame_done_o;
        return o;
    endfunction

    // Expected outputs o cycles after the start edge, from the clamped phase lengths.
    function automatic obs_t model(input int o, input int r, input int i, input int s,
                                   input int sl, input int cm, input logic pv);
        obs_t e;
        int   p, base, done_cyc, k, pos;
        e        = '0;
        p        = sl + cm + SYNC + 1;
        base     = r + i + s + 1;
        done_cyc = base + NPD * p;
        e.valid  = pv;
        e.busy   = (o >= 1 && o <= done_cyc);
        if (o <= r)               e.sh_rst = 1'b1;
        else if (o <= r + i)      e.sw1 = 1'b1;
        else if (o <= r + i + s)  begin e.sh = 1'b1; e.sw2 = 1'b1; end
        else if (o < done_cyc) begin
            k      = (o - base) / p;
            pos    = (o - base) % p;
            e.pd_a = 12'b1 << k;
            e.pd_b = e.pd_a;
            e.sh_cmp = (pos >= sl && pos < sl + cm);
        end
        return e;
    endfunction

    function automatic int clamp1(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    task automatic run_frame(input vec_t v, input logic pv, input ev_t ev, input int ev_at);
        int r, i, s, sl, cm;
        r = clamp1(v.tr); i = clamp1(v.ti); s = clamp1(v.ts);
        sl = clamp1(v.tsl); cm = clamp1(v.tc);
        t_rst_i = 8'(v.tr); t_int_i = 16'(v.ti); t_sh_i = 8'(v.ts);
        t_sel_i = 8'(v.tsl); t_cmp_i = 8'(v.tc);
        pattern = v.pat;
        @(negedge wb_clk_i);
        start_i = 1'b1;
        for (int o = 1; o <= v.vcyc; o++) begin
            @(negedge wb_clk_i);
            start_i = 1'b0;
            if (o < v.vcyc) begin
                check($sformatf("phase_c%0d", o), 64'(sample()), 64'(model(o, r, i, s, sl, cm, pv)));
            end else begin
                check("valid_rise", 64'(code_valid_o), 64'd1);
                check("frame_done_pulse", 64'(frame_done_o), 64'd1);
                check("code", 64'(code_o), 64'(v.pat));
                check("idle_after_frame", 64'({busy_o, sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o, pd_a_o}), 64'd0);
            end
            if (ev != EV_NONE && o == ev_at) begin
                if (ev == EV_RESTART) begin
                    start_i = 1'b1;
                end else if (ev == EV_ABORT) begin
                    abort_i = 1'b1;
                    @(negedge wb_clk_i);
                    abort_i = 1'b0;
                    check("abort_controls", 64'({busy_o, sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o, pd_a_o, pd_b_o, frame_done_o}), 64'd0);
                    check("abort_valid_kept", 64'(code_valid_o), 64'(pv));
                    return;
                end else begin
                    #2 wb_rst_ni = 1'b0;
                    #1 check("async_reset", 64'({sample(), code_o}), 64'd0);
                    #1 wb_rst_ni = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic consume();
        @(negedge wb_clk_i);
        code_ready_i = 1'b1;
        @(negedge wb_clk_i);
        check("consume_valid_clear", 64'({code_valid_o, frame_done_o}), 64'd0);
        code_ready_i = 1'b0;
    endtask

    always @(negedge wb_clk_i) begin
        if (wb_rst_ni) check("pd_onehot", 64'({pd_a_o == pd_b_o, $onehot0(pd_a_o)}), 64'b11);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[4];
    vec_t rv;
    bit   extra_done;

    initial begin
        vecs[0] = '{2, 4, 2, 1, 1, 12'hA5C, 70};
        vecs[1] = '{0, 0, 0, 0, 0, 12'h96F, 65};
        vecs[2] = '{3, 10, 1, 2, 3, 12'h3C9, 112};
        vecs[3] = '{1, 0, 5, 0, 2, 12'h801, 81};

        wb_rst_ni = 1'b0;
        start_i = 1'b0; cont_i = 1'b0; abort_i = 1'b0; code_ready_i = 1'b0;
        t_rst_i = '0; t_int_i = '0; t_sh_i = '0; t_sel_i = '0; t_cmp_i = '0;
        #22 wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        check("reset_state", 64'({sample(), code_o}), 64'd0);

        foreach (vecs[n]) begin
            run_frame(vecs[n], 1'b0, EV_NONE, 0);
            consume();
        end

        // Backpressure: continuous mode with the consumer stalled, then a one-cycle accept.
        t_rst_i = 8'd2; t_int_i = 16'd4; t_sh_i = 8'd2; t_sel_i = 8'd1; t_cmp_i = 8'd1;
        cont_i = 1'b1; pattern = 12'h5A3; extra_done = 1'b0;
        @(negedge wb_clk_i);
        start_i = 1'b1;
        for (int o = 1; o <= 146; o++) begin
            @(negedge wb_clk_i);
            start_i = 1'b0;
            if (o == 70) begin
                check("bp_first_load", 64'({code_valid_o, frame_done_o, sh_rst_o, busy_o, code_o}), 64'({4'b1111, 12'h5A3}));
                pattern = 12'hC3E;
            end else if (o > 70 && frame_done_o) begin
                extra_done = 1'b1;
            end
            if (o == 145) begin
                check("bp_stall_ctrl", 64'({busy_o, sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o, pd_a_o}), 64'({1'b1, 17'd0}));
                check("bp_code_held", 64'({code_valid_o, code_o}), 64'({1'b1, 12'h5A3}));
                check("bp_no_drop", 64'(extra_done), 64'd0);
                code_ready_i = 1'b1;
            end
            if (o == 146) begin
                check("bp_second_load", 64'({code_valid_o, frame_done_o, sh_rst_o, busy_o, code_o}), 64'({4'b1111, 12'hC3E}));
                code_ready_i = 1'b0;
                cont_i = 1'b0;
                abort_i = 1'b1;
            end
        end
        @(negedge wb_clk_i);
        abort_i = 1'b0;
        check("bp_abort_idle", 64'(busy_o), 64'd0);
        consume();

        // Abort during CMP of pair 6 keeps the previously delivered code.
        run_frame(vecs[0], 1'b0, EV_NONE, 0);
        rv = vecs[0]; rv.pat = 12'h1E7;
        run_frame(rv, 1'b1, EV_ABORT, 35);
        check("abort_code_kept", 64'(code_o), 64'(12'hA5C));
        consume();
        run_frame(rv, 1'b0, EV_NONE, 0);

        // Asynchronous reset mid-INTEG clears everything, including the delivered code.
        run_frame(vecs[2], 1'b1, EV_RESET, 6);

        // Start pulses while busy must not disturb timing.
        rv = vecs[0]; rv.pat = 12'h6B2;
        run_frame(rv, 1'b0, EV_RESTART, 3);
        consume();
        rv.pat = 12'h4D1;
        run_frame(rv, 1'b0, EV_RESTART, 40);
        consume();

        for (int n = 0; n < 50; n++) begin
            rv.tr  = int'($urandom_range(0, 3));
            rv.ti  = int'($urandom_range(0, 8));
            rv.ts  = int'($urandom_range(0, 3));
            rv.tsl = int'($urandom_range(0, 3));
            rv.tc  = int'($urandom_range(0, 3));
            rv.pat = 12'($urandom);
            rv.vcyc = clamp1(rv.tr) + clamp1(rv.ti) + clamp1(rv.ts)
                    + NPD * (clamp1(rv.tsl) + clamp1(rv.tc) + SYNC + 1) + 2;
            run_frame(rv, 1'b0, EV_NONE, 0);
            consume();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
